// File: rtl/n64_joybus_rx.sv
// Joybus line receiver: decodes pulse-width bits into an N_BITS word, checks the stop bit and timing.
// Latency: ctrl_clk/frame_err 3 clk_in after the stop-bit rise; no backpressure, strobes are fire-and-forget.
module n64_joybus_rx #(
  parameter int N_BITS      = 32,
  parameter int CLKS_PER_US = 4,
  parameter int TIMEOUT_US  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              din,
  input  logic              enable,
  output logic [N_BITS-1:0] ctrl_state,
  output logic              ctrl_clk,
  output logic              frame_err,
  output logic              busy
);

  localparam int THR  = 2 * CLKS_PER_US;
  localparam int LMAX = 4 * CLKS_PER_US;
  localparam int LMIN = CLKS_PER_US / 2;
  localparam int TO   = TIMEOUT_US * CLKS_PER_US;
  localparam int CMAX = ((LMAX > TO) ? LMAX : TO) + 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(N_BITS + 1);

  localparam logic [CW-1:0] THR_C  = CW'(THR);
  localparam logic [CW-1:0] LMAX_C = CW'(LMAX);
  localparam logic [CW-1:0] LMIN_C = CW'(LMIN);
  localparam logic [CW-1:0] TO_C   = CW'(TO);
  localparam logic [CW-1:0] CMAX_C = CW'(CMAX);
  localparam logic [BW-1:0] NB_C   = BW'(N_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  logic [1:0]        rst_pipe;
  logic              rst_int;
  logic [1:0]        sync_q;
  logic              s;
  logic              s_d;
  logic              fall;

  state_t            state, state_n;
  logic [CW-1:0]     l_cnt, l_n, l_inc;
  logic [CW-1:0]     h_cnt, h_n, h_inc;
  logic [N_BITS-1:0] shreg, sh_n;
  logic [BW-1:0]     bit_cnt, bc_n;
  logic              armed, armed_n;
  logic [N_BITS-1:0] data_n;
  logic              ok_n, err_n;
  logic              is_one;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_int = rst_pipe[1];

  assign s    = sync_q[1];
  assign fall = s_d & ~s;

  always_ff @(posedge clk_in or posedge rst_int) begin
    if (rst_int) begin
      sync_q     <= 2'b11;
      s_d        <= 1'b1;
      state      <= IDLE;
      l_cnt      <= '0;
      h_cnt      <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      armed      <= 1'b1;
      ctrl_state <= '0;
      ctrl_clk   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], din};
      s_d        <= s;
      state      <= state_n;
      l_cnt      <= l_n;
      h_cnt      <= h_n;
      shreg      <= sh_n;
      bit_cnt    <= bc_n;
      armed      <= armed_n;
      ctrl_state <= data_n;
      ctrl_clk   <= ok_n;
      frame_err  <= err_n;
      busy       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    l_n     = l_cnt;
    h_n     = h_cnt;
    sh_n    = shreg;
    bc_n    = bit_cnt;
    armed_n = armed;
    data_n  = ctrl_state;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    l_inc   = (l_cnt == CMAX_C) ? l_cnt : l_cnt + CW'(1);
    h_inc   = (h_cnt == CMAX_C) ? h_cnt : h_cnt + CW'(1);
    is_one  = (l_cnt < THR_C);

    case (state)
      IDLE: begin
        // After a disable, wait for a quiet line so a frame already in flight is not half-decoded.
        if (!armed) begin
          if (!s) begin
            h_n = '0;
          end else if (h_inc >= TO_C) begin
            armed_n = 1'b1;
            h_n     = '0;
          end else begin
            h_n = h_inc;
          end
        end else if (fall) begin
          state_n = LOW;
          l_n     = '0;
          sh_n    = '0;
          bc_n    = '0;
        end
      end

      LOW: begin
        if (!s) begin
          l_n = l_inc;
          if (l_inc > LMAX_C) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (l_cnt < LMIN_C) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (bit_cnt < NB_C) begin
          sh_n    = (shreg << 1) | N_BITS'(is_one);
          bc_n    = bit_cnt + BW'(1);
          h_n     = '0;
          state_n = HIGH;
        end else if (is_one) begin
          ok_n    = 1'b1;
          data_n  = shreg;
          state_n = IDLE;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end

      HIGH: begin
        if (!s) begin
          state_n = LOW;
          l_n     = '0;
        end else begin
          h_n = h_inc;
          if (h_inc >= TO_C) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    if (!enable) begin
      state_n = IDLE;
      ok_n    = 1'b0;
      err_n   = 1'b0;
      data_n  = ctrl_state;
      armed_n = 1'b0;
      h_n     = '0;
    end
  end

endmodule

// File: doc/n64_joybus_rx.md
Name: n64_joybus_rx

Overview:
Parametrised receiver for the N64 Joybus single-wire line, and the successor to the fixed 32-bit read-command receiver. It oversamples the open-drain data line, decodes pulse-width bits of configurable frame length, and checks the stop bit and timing. It delivers the frame word with a one-cycle strobe and flags malformed frames.
It sits between the pad input and the controller-state consumers, clocked from the divM-derived sample clock.

Parameters:
N_BITS, 32, data bits per frame before the stop bit (1..64)
CLKS_PER_US, 4, clk_in cycles per microsecond (even, >=4)
TIMEOUT_US, 8, maximum high time between bits inside a frame, in microseconds

Ports:
clk_in  input  1  sample clock (CLKS_PER_US MHz)
rst  input  1  asynchronous reset, active-high
din  input  1  raw Joybus line, idle high, asynchronous to clk_in
enable  input  1  receiver enable; low aborts any frame and holds IDLE
ctrl_state  output  N_BITS  last good frame, first received bit in MSB
ctrl_clk  output  1  one-cycle strobe: ctrl_state updated this cycle
frame_err  output  1  one-cycle strobe: frame discarded
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Constants: C = CLKS_PER_US. Threshold T = 2C. Max low LMAX = 4C. Min low LMIN = C/2. Timeout TO = TIMEOUT_US*C.
- din passes through a 2-FF synchroniser. Both flops reset to 1. All decoding uses the synchronised value s.
- Counters are sized with $clog2 to hold max(LMAX, TO)+1 without wrap. Both counters saturate and never roll over.
- State machine:
  - IDLE: waits for a falling edge of s. On the edge, clear the low counter, clear the shift register, clear the bit count, and go to LOW.
  - LOW: low counter L increments each cycle s=0. If L exceeds LMAX → error. When s rises, classify L:
    - L < LMIN → error (glitch).
    - L < T → bit 1.
    - L >= T → bit 0.
    - Bit count < N_BITS → shift the bit in from the LSB side (so the first bit ends in the MSB), increment the count, clear the high counter, go to HIGH.
    - Bit count = N_BITS → this pulse is the stop bit. A stop bit classified as 1 → success. A stop bit classified as 0 → error.
  - HIGH: high counter increments while s=1. A falling edge goes to LOW. If the high counter reaches TO → error.
- Success: ctrl_state <= shift register and ctrl_clk=1 for exactly one cycle, on the cycle after the stop-bit rising edge is seen on s. This is at most 3 clk_in cycles after the raw din rise. Then go to IDLE.
- Error: frame_err=1 for one cycle, ctrl_state unchanged, go to IDLE. After an LMAX error, IDLE requires s=1 before a new falling edge is accepted (no re-trigger while held low).
- ctrl_clk and frame_err are never high in the same cycle.
- enable=0: state forced to IDLE in the same cycle. No ctrl_clk or frame_err is generated. ctrl_state is held. A frame whose start is seen while enable=0 is ignored entirely.
- Reset (async assert, sync release):
  - ctrl_state=0, ctrl_clk=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser=1.
  - Reset mid-frame discards the frame with no strobe.
- busy is registered: 1 from the cycle after the start edge until the cycle ctrl_clk or frame_err pulses.
- Back-to-back frames: a falling edge on the cycle after a success is accepted as a new frame start.

Test Plan:
- Default params, 12 MHz bench with clk_in=4 MHz. Idle 5000 ticks, then bit 1 (1 us low/3 us high), 31× bit 0 (3 us low/1 us high), stop (1 us low) → ctrl_clk pulses once, ctrl_state=32'h80000000, frame_err=0. Repeat 50×: 50 strobes, no errors.
- N_BITS=8, bits 1010_0011 then stop → ctrl_state=8'hA3, one ctrl_clk. Then send stop as a 3 us low → frame_err pulse, ctrl_state stays 8'hA3.
- Insert a 10 us high gap after bit 5 of a 32-bit frame → frame_err exactly once, at TO=32 cycles after that rising edge. busy drops. The next well-formed frame decodes correctly.
- Hold din low 6 us mid-frame → frame_err when L=17. No second frame_err or start until din returns high.
- A 1-cycle low glitch on din in IDLE → frame_err (L<2) or no event if filtered by the synchroniser. A 250 ns glitch (1 cycle) never produces ctrl_clk.
- Assert rst mid-frame at bit 12 → all outputs 0 immediately. Drop enable mid-frame → busy=0, no strobes. A subsequent full frame decodes correctly.
